dmem_bus_adapter: RTL and testbench

Sits directly downstream of the pipelined core's MEM-stage data-memory port. Converts the core's single-cycle request signals into a registered request/grant/response bus transaction, and holds the pipeline with a stall until the transaction completes. Reports bus errors and timeouts as a one-cycle fault with the faulting address.

---
 rtl/dmem_bus_adapter_pkg.sv | 15 +
 rtl/dmem_bus_adapter_bus_timeout_counter.sv | 31 +++
 rtl/dmem_bus_adapter.sv | 136 +++++++++++++
 tb/tb_dmem_bus_adapter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_adapter_pkg.sv
// Shared types and constants for the data-memory bus adapter.
package dmem_bus_adapter_pkg;

    // Transaction phases of the adapter FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } dmem_bus_state_t;

    // Default bound on cycles spent in REQ+WAIT before giving up.
    localparam int DMEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/dmem_bus_adapter_bus_timeout_counter.sv
// Cycle counter bounding how long a bus transaction may stay outstanding.
// o_expired flags the cycle in which the count reaches TIMEOUT; the count
// saturates there so a late grant followed by WAIT expires on the next cycle.
module bus_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Count active cycles, restarting whenever a new transaction begins.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // This active cycle is the TIMEOUT-th (or later) one.
    assign o_expired = i_enable && (r_count >= LAST);

endmodule

// File: rtl/dmem_bus_adapter.sv
// MEM-stage data-memory port to registered req/gnt/rvalid bus bridge.
// Stalls the pipeline while a transaction is outstanding and reports bus
// errors and timeouts as a one-cycle fault with the faulting word address.
module dmem_bus_adapter
    import dmem_bus_adapter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_core_addr,
    input  logic [WIDTH-1:0] i_core_wdata,
    input  logic [3:0]       i_core_byteen,
    input  logic             i_core_we,
    input  logic             i_core_re,
    output logic [WIDTH-1:0] o_core_rdata,
    output logic             o_core_stall,
    output logic             o_bus_req,
    output logic             o_bus_we,
    output logic [WIDTH-1:0] o_bus_addr,
    output logic [WIDTH-1:0] o_bus_wdata,
    output logic [3:0]       o_bus_be,
    input  logic             i_bus_gnt,
    input  logic             i_bus_rvalid,
    input  logic [WIDTH-1:0] i_bus_rdata,
    input  logic             i_bus_err,
    output logic             o_fault,
    output logic [WIDTH-1:0] o_fault_addr
);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    dmem_bus_state_t  r_state;
    dmem_bus_state_t  w_next;
    logic             w_core_req;
    logic             w_start;
    logic             w_expired;
    logic             w_timeout;
    logic             w_resp_ok;
    logic             r_req;
    logic             r_we;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [3:0]       r_be;
    logic [WIDTH-1:0] r_rdata;
    logic             r_err;
    logic [WIDTH-1:0] r_fault_addr;

    assign w_core_req = i_core_we | i_core_re;
    assign w_start    = (r_state == ST_IDLE) && w_core_req;
    // Response accepted only while waiting for it; anything else is stray.
    assign w_resp_ok  = (r_state == ST_WAIT) && i_bus_rvalid;
    // Grant and response both take priority over expiry.
    assign w_timeout  = w_expired &&
                        (((r_state == ST_REQ) && !i_bus_gnt) ||
                         ((r_state == ST_WAIT) && !i_bus_rvalid));

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_start),
        .i_enable  ((r_state == ST_REQ) || (r_state == ST_WAIT)),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_core_req) w_next = ST_REQ;
            ST_REQ: begin
                if (i_bus_gnt)      w_next = ST_WAIT;
                else if (w_expired) w_next = ST_RESP;
            end
            ST_WAIT: if (i_bus_rvalid || w_expired) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request capture, bus request flag and response/fault bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            if (w_start) begin
                r_addr  <= i_core_addr & ALIGN_MASK;
                r_wdata <= i_core_wdata;
                r_be    <= i_core_byteen;
                r_we    <= i_core_we;
                r_req   <= 1'b1;
            end else if ((r_state == ST_REQ) && (i_bus_gnt || w_expired)) begin
                r_req   <= 1'b0;
            end

            if (w_resp_ok) begin
                r_rdata <= i_bus_err ? '0 : i_bus_rdata;
                r_err   <= i_bus_err;
                if (i_bus_err) r_fault_addr <= r_addr;
            end else if (w_timeout) begin
                r_rdata      <= '0;
                r_err        <= 1'b1;
                r_fault_addr <= r_addr;
            end
        end
    end

    assign o_core_stall = w_start || (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign o_core_rdata = r_rdata;
    assign o_bus_req    = r_req;
    assign o_bus_we     = r_we;
    assign o_bus_addr   = r_addr;
    assign o_bus_wdata  = r_wdata;
    assign o_bus_be     = r_be;
    assign o_fault      = (r_state == ST_RESP) && r_err;
    assign o_fault_addr = r_fault_addr;

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Directed bench for dmem_bus_adapter: each transaction is described by its
// grant/response delays, the expected per-cycle outputs follow from that
// timeline, and one compare process checks them every cycle.
module tb_dmem_bus_adapter;
    localparam int T = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_core_addr, i_core_wdata, i_bus_rdata;
    logic [3:0]  i_core_byteen;
    logic        i_core_we, i_core_re, i_bus_gnt, i_bus_rvalid, i_bus_err;
    logic [31:0] o_core_rdata, o_bus_addr, o_bus_wdata, o_fault_addr;
    logic [3:0]  o_bus_be;
    logic        o_core_stall, o_bus_req, o_bus_we, o_fault;

    dmem_bus_adapter #(.WIDTH(32), .TIMEOUT(T)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_core_addr(i_core_addr), .i_core_wdata(i_core_wdata),
        .i_core_byteen(i_core_byteen), .i_core_we(i_core_we), .i_core_re(i_core_re),
        .o_core_rdata(o_core_rdata), .o_core_stall(o_core_stall),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
        .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
        .i_bus_err(i_bus_err), .o_fault(o_fault), .o_fault_addr(o_fault_addr)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0, n_bad = 0;
    int req_cnt, stall_cnt, fault_cnt;
    logic [31:0] last_addr;
    logic        last_we;

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_resp, exp_fault, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rdata, m_fault_addr;
    logic [3:0]  exp_be;

    task automatic chk1(input string nm, input logic act, input logic want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, want, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    // Per-cycle comparison against the timeline expectations.
    always @(negedge i_clk) begin
        if (chk_en) begin
            chk1("stall", o_core_stall, exp_stall);
            chk1("req", o_bus_req, exp_req);
            chk1("fault", o_fault, exp_fault);
            chk32("fault_addr", o_fault_addr, m_fault_addr);
            if (exp_req) begin
                chk1("bus_we", o_bus_we, exp_we);
                chk32("bus_addr", o_bus_addr, exp_addr);
                chk32("bus_wdata", o_bus_wdata, exp_wdata);
                chk32("bus_be", {28'b0, o_bus_be}, {28'b0, exp_be});
            end
            if (exp_resp) chk32("rdata", o_core_rdata, exp_rdata);
            if (o_core_stall) stall_cnt++;
            if (o_fault) fault_cnt++;
            if (o_bus_req) begin
                req_cnt++;
                last_addr = o_bus_addr;
                last_we   = o_bus_we;
            end
        end
    end

    task automatic idle(input int n, input logic rv);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
            i_core_we = 0; i_core_re = 0; i_core_byteen = 0;
            i_bus_gnt = 0; i_bus_rvalid = rv; i_bus_err = 0; i_bus_rdata = 32'h5555AAAA;
            exp_stall = 0; exp_req = 0; exp_resp = 0; exp_fault = 0;
        end
    endtask

    // One core access. gw = cycles without grant before the grant cycle,
    // rw = WAIT cycles without response before the response cycle.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic we, input logic re,
                       input int gw, input int rw, input logic err,
                       input logic [31:0] rdata, input logic stray);
        int R, Wn, kr, kt;
        logic granted, ok;
        granted = (gw + 1 <= T);
        R  = granted ? gw + 1 : T;
        ok = 1'b0; Wn = 0;
        if (granted) begin
            kr = gw + rw + 2;                     // active cycle holding rvalid
            kt = (T > gw + 2) ? T : gw + 2;       // first WAIT cycle that can expire
            ok = (kr <= kt);
            Wn = ok ? rw + 1 : kt - (gw + 1);
        end
        req_cnt = 0; stall_cnt = 0; fault_cnt = 0;
        for (int c = 0; c <= R + Wn + 1; c++) begin
            @(posedge i_clk); #1;
            if (c == 0) begin
                i_core_addr = addr; i_core_wdata = wdata; i_core_byteen = be;
                i_core_we = we; i_core_re = re;
            end
            i_bus_gnt    = granted && (c == gw + 1);
            i_bus_rvalid = (ok && c == R + Wn) || (stray && c == 1);
            i_bus_err    = err && ok && (c == R + Wn);
            i_bus_rdata  = (stray && c == 1) ? 32'hBAD0BAD0 : rdata;
            exp_stall = (c <= R + Wn);
            exp_req   = (c >= 1) && (c <= R);
            exp_we    = we;
            exp_addr  = addr & 32'hFFFF_FFFC;
            exp_wdata = wdata;
            exp_be    = be;
            exp_resp  = (c == R + Wn + 1);
            exp_fault = exp_resp && (!ok || err);
            exp_rdata = (ok && !err) ? rdata : 32'h0;
            if (exp_fault) m_fault_addr = addr & 32'hFFFF_FFFC;
        end
        @(negedge i_clk); #1;
    endtask

    initial begin
        i_reset = 1; i_core_addr = 0; i_core_wdata = 0; i_core_byteen = 0;
        i_core_we = 0; i_core_re = 0; i_bus_gnt = 0; i_bus_rvalid = 0;
        i_bus_rdata = 0; i_bus_err = 0; m_fault_addr = 0;
        exp_stall = 0; exp_req = 0; exp_resp = 0; exp_fault = 0;
        exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_be = 0; exp_rdata = 0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk1("rst_req", o_bus_req, 1'b0);
        chk1("rst_stall", o_core_stall, 1'b0);
        chk1("rst_fault", o_fault, 1'b0);
        chk1("rst_we", o_bus_we, 1'b0);
        chk32("rst_addr", o_bus_addr, 32'h0);
        chk32("rst_rdata", o_core_rdata, 32'h0);
        chk32("rst_faddr", o_fault_addr, 32'h0);
        chk32("rst_be", {28'b0, o_bus_be}, 32'h0);
        @(posedge i_clk); #1; i_reset = 0;
        chk_en = 1;
        idle(2, 1'b0);

        // Minimum-latency load.
        txn(32'h0000_1006, 32'h0, 4'hF, 1'b0, 1'b1, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0);
        chk32("ld_addr", last_addr, 32'h0000_1004);
        chk32("ld_req_cycles", req_cnt, 1);
        chk32("ld_stall_cycles", stall_cnt, 3);
        chk32("ld_rdata", o_core_rdata, 32'hDEADBEEF);
        chk32("ld_faults", fault_cnt, 0);
        idle(1, 1'b0);

        // Store, grant late, response coincides with the expiry cycle.
        txn(32'h0000_2000, 32'h12345678, 4'b0011, 1'b1, 1'b0, 2, 0, 1'b0, 32'h0, 1'b0);
        chk32("st_stall_cycles", stall_cnt, 5);
        chk1("st_we", last_we, 1'b1);
        idle(1, 1'b0);

        // Load with bus error.
        txn(32'h0000_0200, 32'h0, 4'hF, 1'b0, 1'b1, 0, 1, 1'b1, 32'hFFFF0000, 1'b0);
        chk32("err_rdata", o_core_rdata, 32'h0);
        chk32("err_faults", fault_cnt, 1);
        chk32("err_faddr", o_fault_addr, 32'h0000_0200);
        idle(2, 1'b0);
        chk1("err_pulse_gone", o_fault, 1'b0);

        // Good load, then a load that never gets a grant.
        txn(32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b1, 0, 0, 1'b0, 32'hCAFEF00D, 1'b0);
        txn(32'h0000_0404, 32'h0, 4'hF, 1'b0, 1'b1, 20, 0, 1'b0, 32'h0, 1'b0);
        chk32("to_req_cycles", req_cnt, T);
        chk32("to_stall_cycles", stall_cnt, T + 1);
        chk32("to_faults", fault_cnt, 1);
        idle(3, 1'b1);
        chk32("to_late_rvalid", o_core_rdata, 32'h0);

        // Grant on the expiry cycle: response next cycle wins, one later times out.
        txn(32'h0000_0500, 32'h0, 4'hF, 1'b0, 1'b1, 3, 0, 1'b0, 32'h0BADF00D, 1'b0);
        chk32("gnt_edge_stall", stall_cnt, 6);
        txn(32'h0000_0600, 32'h0, 4'hF, 1'b0, 1'b1, 3, 1, 1'b0, 32'h0, 1'b0);
        chk32("gnt_edge_to_fault", fault_cnt, 1);
        idle(1, 1'b0);

        // Stray rvalid during REQ; zero byte-enable write.
        txn(32'h0000_0700, 32'h0, 4'hF, 1'b0, 1'b1, 1, 0, 1'b0, 32'h13572468, 1'b1);
        chk32("stray_rdata", o_core_rdata, 32'h13572468);
        txn(32'h0000_0800, 32'hA5A5A5A5, 4'b0000, 1'b1, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
        chk1("be0_is_write", last_we, 1'b1);

        // Back-to-back: second access has we+re and must be a write.
        txn(32'h0000_0040, 32'h0, 4'hF, 1'b0, 1'b1, 0, 0, 1'b0, 32'h11112222, 1'b0);
        txn(32'h0000_0044, 32'h99998888, 4'hF, 1'b1, 1'b1, 0, 0, 1'b0, 32'h0, 1'b0);
        chk1("b2b_we", last_we, 1'b1);
        chk32("b2b_stall", stall_cnt, 3);
        idle(1, 1'b0);

        // Reset while waiting for the response.
        chk_en = 0;
        @(posedge i_clk); #1;
        i_core_addr = 32'h300; i_core_re = 1; i_core_we = 0;
        @(posedge i_clk); #1; i_bus_gnt = 1;
        @(posedge i_clk); #1; i_bus_gnt = 0; i_reset = 1; i_core_re = 0;
        @(posedge i_clk); #1; i_reset = 0;
        i_bus_rvalid = 1; i_bus_rdata = 32'h77777777;
        @(negedge i_clk);
        chk1("rstw_stall", o_core_stall, 1'b0);
        chk1("rstw_req", o_bus_req, 1'b0);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1; i_bus_rvalid = 0;
        @(negedge i_clk);
        chk32("rstw_rdata", o_core_rdata, 32'h0);
        chk1("rstw_req2", o_bus_req, 1'b0);
        m_fault_addr = 32'h0;
        idle(1, 1'b0);
        chk_en = 1;
        idle(3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
